// File: rtl/bmult_pkg.sv
// Shared widths, FSM state type and partial-product shift helper for the
// iterative 48x48 multiplier.
package bmult_pkg;
  localparam int HW = 24;
  localparam int FW = 48;
  localparam int PW = 96;

  typedef enum logic [1:0] {IDLE, MUL, DONE} bm_state_t;

  // Tag order is (lo,lo), (lo,hi), (hi,lo), (hi,hi).
  function automatic logic [6:0] pp_shift(input logic [1:0] tag);
    case (tag)
      2'd0:    pp_shift = 7'd0;
      2'd3:    pp_shift = 7'd48;
      default: pp_shift = 7'd24;
    endcase
  endfunction
endpackage

// File: rtl/Bmult24x24.sv
// Single-stage 24x24 unsigned multiplier core. The product is registered and
// has no reset.
module Bmult24x24 (
  input  logic        clk,
  input  logic [23:0] A,
  input  logic [23:0] B,
  output logic [47:0] P
);
  always_ff @(posedge clk) P <= A * B;
endmodule

// File: rtl/bmult48_iter.sv
// 48x48 unsigned multiplier that sequences four half-products through one
// Bmult24x24 core and shift-accumulates them into a 96-bit result.
module bmult48_iter #(
  parameter int HW = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*HW-1:0] A,
  input  logic [2*HW-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4*HW-1:0] P
);
  import bmult_pkg::*;

  if (HW != bmult_pkg::HW) begin : g_bad_hw
    $error("bmult48_iter: HW must be 24 to match Bmult24x24");
  end

  bm_state_t       state_q, state_d;
  logic [FW-1:0]   a_q, a_d, b_q, b_d;
  logic [2:0]      k_q, k_d;
  logic            vld_q, vld_d;
  logic [1:0]      tag_q, tag_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [HW-1:0]   core_a, core_b;
  logic [FW-1:0]   core_p;

  // k[1] picks the A half, k[0] the B half.
  assign core_a = k_q[1] ? a_q[FW-1:HW] : a_q[HW-1:0];
  assign core_b = k_q[0] ? b_q[FW-1:HW] : b_q[HW-1:0];

  Bmult24x24 u_core (
    .clk (clk),
    .A   (core_a),
    .B   (core_b),
    .P   (core_p)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    k_d         = k_q;
    vld_d       = 1'b0;
    tag_d       = tag_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (vld_q)
      acc_d = acc_q + ({{(PW-FW){1'b0}}, core_p} << pp_shift(tag_q));

    case (state_q)
      IDLE: if (in_valid) begin
        a_d        = A;
        b_d        = B;
        k_d        = 3'd0;
        acc_d      = '0;
        state_d    = MUL;
        in_ready_d = 1'b0;
      end
      MUL: begin
        // Flag/tag follow the product the core captures at this edge.
        if (!k_q[2]) begin
          vld_d = 1'b1;
          tag_d = k_q[1:0];
          k_d   = k_q + 3'd1;
        end
        if (vld_q && tag_q == 2'd3) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end
      DONE: if (out_ready) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      k_q         <= '0;
      vld_q       <= 1'b0;
      tag_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      k_q         <= k_d;
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign P         = acc_q;
endmodule

// File: tb/tb_bmult48_iter.sv
// Directed-vector bench for bmult48_iter: latency, handshake, backpressure,
// mid-op reset and a short randomized run against A*B.
module tb_bmult48_iter;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [47:0] A, B;
  logic [95:0] P;
  int          n_vec = 0, n_err = 0;

  bmult48_iter #(.HW(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .P         (P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tg, obs, exp);
    end
  endtask

  // Accept one pair, check latency/product, stall in DONE, then handshake.
  task automatic mul_op(input string tg, input logic [47:0] a, input logic [47:0] b,
                        input logic [95:0] exp, input int stall, input bit chk_lat);
    int n;
    logic [95:0] held;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk({tg, ":rdy"}, {95'd0, in_ready}, 96'd1);
    A = a; B = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    A = ~a; B = ~b;
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (chk_lat) chk({tg, ":lat"}, 96'(n), 96'd5);
    chk({tg, ":P"}, P, exp);
    chk({tg, ":irdy_dn"}, {95'd0, in_ready}, 96'd0);
    held = P;
    for (int i = 0; i < stall; i++) begin
      in_valid = ~in_valid;
      A = 48'($urandom); B = 48'($urandom);
      @(negedge clk);
      chk({tg, ":hold"}, {P, out_valid, in_ready}, {held, 1'b1, 1'b0});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tg, ":hs"}, {94'd0, out_valid, in_ready}, 96'b01);
  endtask

  initial begin
    logic [47:0] ra, rb;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    rst = 1'b1;
    #1;
    chk("rst:ov_P", {P, out_valid}, 97'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst:irdy", {95'd0, in_ready}, 96'd1);

    mul_op("zero", 48'h123456789ABC, 48'h0, 96'h0, 0, 1);
    mul_op("ones", 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF,
           96'hFFFFFFFFFFFE000000000001, 0, 1);
    mul_op("x48", 48'h000001000000, 48'h000001000000, 96'h1000000000000, 0, 1);
    mul_op("locarry", 48'hFFFFFFFFFFFF, 48'h000000000002, 96'h1FFFFFFFFFFFE, 0, 1);
    mul_op("bp", 48'h000000ABCDEF, 48'h000000000010, 96'hABCDEF0, 4, 1);
    mul_op("after_bp", 48'h800000000000, 48'h000000000003, 96'h1800000000000, 0, 1);

    // Reset three cycles after accepting a pair.
    A = 48'hFFFFFFFFFFFF; B = 48'hFFFFFFFFFFFF; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst:ov_P", {P, out_valid}, 97'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst:irdy", {95'd0, in_ready}, 96'd1);
    mul_op("post_rst", 48'd3, 48'd5, 96'd15, 0, 1);

    for (int i = 0; i < 200; i++) begin
      ra = {16'($urandom), 32'($urandom)};
      rb = {16'($urandom), 32'($urandom)};
      if (i % 17 == 0) ra = 48'hFFFFFFFFFFFF;
      mul_op("rnd", ra, rb, {48'd0, ra} * {48'd0, rb}, int'($urandom_range(0, 3)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
